// File: rtl/dvfx_delay_pkg.sv
// Shared constants for the effects-chain delay-line scheduler: default
// widths, the ms-to-samples factor, tap indices and FSM state encodings.
package dvfx_delay_pkg;

    localparam int DATA_W_DEF         = 12;
    localparam int ADDR_W_DEF         = 14;
    localparam int SAMPLES_PER_MS_DEF = 8;
    localparam int DEL_W              = 12;
    localparam int NUM_TAPS           = 4;

    // Tap order on the shared RAM port, which is also the tap1..tap4 order.
    localparam int TAP_ECHO   = 0;
    localparam int TAP_CHORUS = 1;
    localparam int TAP_PHASER = 2;
    localparam int TAP_REVERB = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_WR   = 3'd1;
    localparam state_t ST_RD0  = 3'd2;
    localparam state_t ST_RD1  = 3'd3;
    localparam state_t ST_RD2  = 3'd4;
    localparam state_t ST_RD3  = 3'd5;
    localparam state_t ST_CAP  = 3'd6;

endpackage

// File: rtl/delay_ms_to_samples.sv
// Converts a tap delay in milliseconds to a sample offset and clamps it to
// the largest offset the circular buffer can hold (DEPTH-1).
module delay_ms_to_samples
    import dvfx_delay_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int SAMPLES_PER_MS = SAMPLES_PER_MS_DEF
) (
    input  logic [DEL_W-1:0]  i_ms,
    output logic [ADDR_W-1:0] o_samples
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam logic [31:0] MAX_D = 32'(DEPTH - 1);

    logic [15:0] w_prod;

    assign w_prod = 16'(i_ms) * 16'(SAMPLES_PER_MS);

    // Clamp happens before the caller subtracts from the write address.
    always_comb begin
        if ({16'd0, w_prod} > MAX_D) o_samples = ADDR_W'(MAX_D);
        else                         o_samples = ADDR_W'(w_prod);
    end

endmodule

// File: rtl/delay_tap_scheduler.sv
// Delay-line RAM sequencer: on each sample strobe writes the sample into a
// circular buffer, then reads four delayed taps (echo, chorus, phaser,
// reverb). Fixed 7-cycle latency from accept to taps_valid.
// Optional build macro PRIME_MASK_EN: taps reaching further back than the
// number of samples written since reset read as 0.
module delay_tap_scheduler
    import dvfx_delay_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int SAMPLES_PER_MS = SAMPLES_PER_MS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DEL_W-1:0]  del1,
    input  logic [DEL_W-1:0]  del2,
    input  logic [DEL_W-1:0]  del3,
    input  logic [DEL_W-1:0]  del4,
    input  logic [3:0]        tap_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] tap1,
    output logic [DATA_W-1:0] tap2,
    output logic [DATA_W-1:0] tap3,
    output logic [DATA_W-1:0] tap4,
    output logic              taps_valid,
    output logic              busy,
    output logic              overrun
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_wa;
    logic [DEL_W-1:0]  r_del [NUM_TAPS];
    logic [3:0]        r_en;
    logic [3:0]        r_ok;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_tap [NUM_TAPS];
    logic              r_taps_valid;
    logic              r_overrun;

    logic              w_issue;
    logic [1:0]        w_issue_idx;
    logic              w_cap;
    logic [1:0]        w_cap_idx;
    logic [ADDR_W-1:0] w_dk;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_tap_ok;

    // Which tap's read address is registered this cycle, and which tap's
    // RAM data arrives this cycle (one state later, RAM latency 1).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_issue     = 1'b0;
        w_issue_idx = 2'd0;
        w_cap       = 1'b0;
        w_cap_idx   = 2'd0;
        case (r_state)
            ST_WR:  begin w_issue = 1'b1; w_issue_idx = 2'(TAP_ECHO);   end
            ST_RD0: begin w_issue = 1'b1; w_issue_idx = 2'(TAP_CHORUS); end
            ST_RD1: begin w_issue = 1'b1; w_issue_idx = 2'(TAP_PHASER);
                          w_cap   = 1'b1; w_cap_idx   = 2'(TAP_ECHO);   end
            ST_RD2: begin w_issue = 1'b1; w_issue_idx = 2'(TAP_REVERB);
                          w_cap   = 1'b1; w_cap_idx   = 2'(TAP_CHORUS); end
            ST_RD3: begin w_cap   = 1'b1; w_cap_idx   = 2'(TAP_PHASER); end
            ST_CAP: begin w_cap   = 1'b1; w_cap_idx   = 2'(TAP_REVERB); end
            default: ;
        endcase
    end

    delay_ms_to_samples #(
        .ADDR_W         (ADDR_W),
        .SAMPLES_PER_MS (SAMPLES_PER_MS)
    ) u_ms_to_samples (
        .i_ms      (r_del[w_issue_idx]),
        .o_samples (w_dk)
    );

    // Natural ADDR_W-bit wrap gives the modulo-DEPTH subtraction.
    assign w_rd_addr = r_wa - w_dk;

`ifdef PRIME_MASK_EN
    logic [ADDR_W-1:0] r_fill;
    logic [ADDR_W-1:0] w_fill_eff;

    // Saturating count of samples written since reset.
    always_ff @(posedge clk) begin
        if (rst)                                    r_fill <= '0;
        else if (r_state == ST_WR && r_fill != '1)  r_fill <= r_fill + ADDR_W'(1);
    end

    // The echo address is formed during WR, before the fill count for the
    // current write has landed, so include that write here.
    assign w_fill_eff = (r_state == ST_WR && r_fill != '1) ? r_fill + ADDR_W'(1) : r_fill;
    assign w_tap_ok   = (w_dk < w_fill_eff);
`else
    assign w_tap_ok = 1'b1;
`endif

    // Frame sequencing, RAM port drive, tap capture and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wptr       <= '0;
            r_wa         <= '0;
            r_en         <= '0;
            r_ok         <= '0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_taps_valid <= 1'b0;
            r_overrun    <= 1'b0;
            // NOTE: these arrays are a handful of flops, not RAM, so resetting them costs nothing; the BRAM itself is never cleared.
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_del[k] <= '0;
                r_tap[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            r_taps_valid <= 1'b0;

            if (r_state != ST_IDLE && sample_valid) r_overrun <= 1'b1;

            if (w_issue) begin
                r_mem_we             <= 1'b0;
                r_mem_addr           <= w_rd_addr;
                r_ok[w_issue_idx]    <= w_tap_ok;
            end

            if (w_cap)
                r_tap[w_cap_idx] <= (r_en[w_cap_idx] && r_ok[w_cap_idx]) ? mem_rdata : '0;

            case (r_state)
                ST_IDLE: if (sample_valid) begin
                    r_del[TAP_ECHO]   <= del1;
                    r_del[TAP_CHORUS] <= del2;
                    r_del[TAP_PHASER] <= del3;
                    r_del[TAP_REVERB] <= del4;
                    r_en              <= tap_en;
                    r_wa              <= r_wptr;
                    r_mem_addr        <= r_wptr;
                    r_mem_we          <= 1'b1;
                    r_mem_wdata       <= sample_in;
                    r_state           <= ST_WR;
                end
                ST_WR: begin
                    r_wptr  <= r_wptr + ADDR_W'(1);
                    r_state <= ST_RD0;
                end
                ST_RD0: r_state <= ST_RD1;
                ST_RD1: r_state <= ST_RD2;
                ST_RD2: r_state <= ST_RD3;
                ST_RD3: r_state <= ST_CAP;
                ST_CAP: begin
                    r_taps_valid <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign tap1       = r_tap[TAP_ECHO];
    assign tap2       = r_tap[TAP_CHORUS];
    assign tap3       = r_tap[TAP_PHASER];
    assign tap4       = r_tap[TAP_REVERB];
    assign taps_valid = r_taps_valid;
    assign busy       = (r_state != ST_IDLE);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// Self-checking bench for delay_tap_scheduler: BRAM model plus a reference
// model of the buffer contents indexed by its own write pointer.
// Honours PRIME_MASK_EN when the build defines it.
module tb_delay_tap_scheduler;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int SPM    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_in;
    logic [11:0]       del1, del2, del3, del4;
    logic [3:0]        tap_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] tap1, tap2, tap3, tap4;
    logic              taps_valid;
    logic              busy;
    logic              overrun;

    always #5 clk = ~clk;

    delay_tap_scheduler #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .SAMPLES_PER_MS (SPM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .del1         (del1),
        .del2         (del2),
        .del3         (del3),
        .del4         (del4),
        .tap_en       (tap_en),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .tap1         (tap1),
        .tap2         (tap2),
        .tap3         (tap3),
        .tap4         (tap4),
        .taps_valid   (taps_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Single-port synchronous BRAM, read data one cycle after address.
    logic [DATA_W-1:0] bram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                m_wptr;
    int                m_fill;
    logic [DATA_W-1:0] last_exp [4];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dk_of(input logic [11:0] d);
        int p;
        p = int'(d) * SPM;
        return (p > DEPTH - 1) ? DEPTH - 1 : p;
    endfunction

    function automatic int rd_addr(input int wa, input int dk);
        return (wa - dk + DEPTH) % DEPTH;
    endfunction

    function automatic logic [DATA_W-1:0] exp_tap(input int wa, input logic [11:0] d, input logic en);
        int dk;
        dk = dk_of(d);
        if (!en) return '0;
`ifdef PRIME_MASK_EN
        if (dk > m_fill - 1) return '0;
`endif
        return ref_mem[rd_addr(wa, dk)];
    endfunction

    task automatic model_write(input logic [DATA_W-1:0] s, output int wa);
        wa = m_wptr;
        ref_mem[wa] = s;
        m_wptr = (m_wptr + 1) % DEPTH;
        if (m_fill < DEPTH - 1) m_fill++;
    endtask

    task automatic scramble_inputs();
        sample_in = DATA_W'($urandom);
        del1 = 12'($urandom); del2 = 12'($urandom);
        del3 = 12'($urandom); del4 = 12'($urandom);
        tap_en = 4'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of
    // cycle 7, so a following call is accepted in the taps_valid cycle.
    task automatic run_frame(input logic [DATA_W-1:0] s,
                             input logic [11:0] d1, input logic [11:0] d2,
                             input logic [11:0] d3, input logic [11:0] d4,
                             input logic [3:0] en, input bit full, input int inject_cyc);
        logic [11:0]       d [4];
        logic [DATA_W-1:0] et [4];
        int                wa;
        d = '{d1, d2, d3, d4};
        sample_valid = 1'b1; sample_in = s;
        del1 = d1; del2 = d2; del3 = d3; del4 = d4; tap_en = en;
        @(posedge clk);
        model_write(s, wa);
        for (int k = 0; k < 4; k++) et[k] = exp_tap(wa, d[k], en[k]);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (full) begin
                if (c == 1) begin
                    check("wr_we", 32'(mem_we), 32'd1);
                    check("wr_addr", 32'(mem_addr), 32'(wa));
                    check("wr_data", 32'(mem_wdata), 32'(s));
                    check("busy_wr", 32'(busy), 32'd1);
                end else if (c <= 5) begin
                    check("rd_we", 32'(mem_we), 32'd0);
                    check("rd_addr", 32'(mem_addr), 32'(rd_addr(wa, dk_of(d[c-2]))));
                end
                if (c < 7) check("tv_early", 32'(taps_valid), 32'd0);
            end
            if (c == 7) begin
                check("taps_valid", 32'(taps_valid), 32'd1);
                check("busy_idle", 32'(busy), 32'd0);
                check("tap1", 32'(tap1), 32'(et[0]));
                check("tap2", 32'(tap2), 32'(et[1]));
                check("tap3", 32'(tap3), 32'(et[2]));
                check("tap4", 32'(tap4), 32'(et[3]));
            end
            scramble_inputs();
            sample_valid = (c == inject_cyc);
        end
        last_exp = et;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_taps", {8'd0, tap1 | tap2, tap3 | tap4}, 32'd0);
        check("rst_flags", {29'd0, taps_valid, busy, overrun}, 32'd0);
        rst = 1'b0;
        m_wptr = 0;
        m_fill = 0;
    endtask

    initial begin
        int wa_dummy;
        for (int a = 0; a < DEPTH; a++) begin
            bram[a] = '0;
            ref_mem[a] = '0;
        end
        rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
        del1 = '0; del2 = '0; del3 = '0; del4 = '0; tap_en = '0;
        m_wptr = 0; m_fill = 0;

        do_reset();

        // Single sample, zero delay returns the sample just written.
        run_frame(12'h123, 12'd0, 12'd0, 12'd0, 12'd0, 4'hF, 1'b1, 0);
        check("first_tap4", 32'(tap4), 32'h123);

        // 600 back-to-back frames, 50 ms echo; each accepted in the taps_valid cycle.
        @(negedge clk);
        for (int i = 0; i < 600; i++)
            run_frame(DATA_W'(i), 12'd50, 12'($urandom), 12'($urandom), 12'($urandom), 4'h1, 1'b0, 0);
        check("echo_400", 32'(tap1), 32'd199);
        check("b2b_no_overrun", 32'(overrun), 32'd0);

        // Random frames with mixed short and long delays, some idle gaps.
        for (int i = 0; i < 40; i++) begin
            logic [11:0] rd [4];
            for (int k = 0; k < 4; k++)
                rd[k] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 80)) : 12'($urandom);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_frame(DATA_W'($urandom), rd[0], rd[1], rd[2], rd[3], 4'($urandom), 1'b1, 0);
        end

        // Clamp: 4095 and 2048 ms clamp to DEPTH-1, 2047 ms does not.
        @(negedge clk);
        run_frame(12'hABC, 12'd4095, 12'd2048, 12'd2047, 12'd0, 4'hF, 1'b1, 0);

        // Taps hold through idle cycles.
        repeat (5) @(negedge clk);
        check("hold_tap1", 32'(tap1), 32'(last_exp[0]));
        check("hold_tap3", 32'(tap3), 32'(last_exp[2]));

        // Strobe in cycle 3 is dropped and sets the sticky overrun.
        run_frame(12'h5A5, 12'd0, 12'd1, 12'd2, 12'd3, 4'hF, 1'b1, 3);
        check("overrun_set", 32'(overrun), 32'd1);
        @(negedge clk);
        run_frame(12'h0F0, 12'd0, 12'd1, 12'd0, 12'd0, 4'hF, 1'b1, 0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset during RD2 aborts the frame.
        @(negedge clk);
        sample_valid = 1'b1; sample_in = 12'h777;
        del1 = 12'd0; del2 = 12'd0; del3 = 12'd0; del4 = 12'd0; tap_en = 4'hF;
        @(posedge clk);
        model_write(12'h777, wa_dummy);
        @(negedge clk); sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_taps", {8'd0, tap1 | tap2, tap3 | tap4}, 32'd0);
        check("abort_flags", {28'd0, taps_valid, busy, overrun, mem_we}, 32'd0);
        rst = 1'b0;
        m_wptr = 0;
        m_fill = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_tv", 32'(taps_valid), 32'd0);
        end
        run_frame(12'h321, 12'd0, 12'd1, 12'd4095, 12'd0, 4'hF, 1'b1, 0);
        check("after_abort_tap1", 32'(tap1), 32'h321);

        // Short delays straddling address 0 right after reset.
        run_frame(12'h011, 12'd1, 12'd0, 12'd2, 12'd1, 4'hF, 1'b1, 0);
        run_frame(12'h022, 12'd1, 12'd0, 12'd0, 12'd1, 4'hB, 1'b1, 0);
`ifdef PRIME_MASK_EN
        check("prime_mask", 32'(tap1), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
